sw_conditioner: RTL and testbench

Input conditioning stage placed directly upstream of the picomips core. It synchronises the raw slide switches SW[8:0] into the Clock domain and debounces the SW[8] handshake switch. It also freezes the SW[7:0] data value while the handshake is asserted. The core's hold-until-equal and hold-until-not-equal instructions therefore see exactly one clean transition per physical toggle and a stable operand.

---
 rtl/picomips_pkg.sv | 17 +
 rtl/sw_conditioner_if.sv | 33 +++
 rtl/sync2.sv | 30 +++
 rtl/sw_conditioner.sv | 126 ++++++++++++
 tb/tb_sw_conditioner.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/picomips_pkg.sv
// Shared definitions for the picomips input path.
//   hs_state_t : debounce state machine states for the SW[8] handshake
//   HS_BIT     : index of the handshake switch within SW[8:0]
//   DATA_W     : width of the switch data operand SW[7:0]
package picomips_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE,
        LOW_PEND,
        HIGH_STABLE,
        HIGH_PEND
    } hs_state_t;

    localparam int unsigned HS_BIT = 8;
    localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch conditioning bus between the raw switch pins and the picomips core.
//   SW_raw   : raw switch pins, [8] handshake, [7:0] data
//   SW_clean : conditioned switches presented to the core
//   hs_rise  : one-cycle pulse on the debounced handshake going 0->1
//   hs_fall  : one-cycle pulse on the debounced handshake going 1->0
//   bouncing : debounce counter is nonzero
// master drives SW_raw and observes the rest; slave is the conditioner.
interface sw_conditioner_if;
    import picomips_pkg::*;

    logic [HS_BIT:0] SW_raw;
    logic [HS_BIT:0] SW_clean;
    logic            hs_rise;
    logic            hs_fall;
    logic            bouncing;

    modport master (
        output SW_raw,
        input  SW_clean,
        input  hs_rise,
        input  hs_fall,
        input  bouncing
    );

    modport slave (
        input  SW_raw,
        output SW_clean,
        output hs_rise,
        output hs_fall,
        output bouncing
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser, asynchronously reset to zero.
//   Clock  : destination clock
//   nReset : asynchronous active-low reset
//   d      : asynchronous input bits
//   q      : synchronised bits, two rising edges after d
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sw_conditioner.sv
// Input conditioning for the picomips slide switches.
// Synchronises SW_raw[8:0], debounces the SW[8] handshake and freezes the
// SW[7:0] operand while the debounced handshake is high, so the core's
// hold-until instructions see one clean transition per toggle.
//   Clock  : system clock, rising edge
//   nReset : asynchronous active-low reset
//   sw     : conditioning bus (slave side), see sw_conditioner_if
module sw_conditioner
    import picomips_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic            Clock,
    input  logic            nReset,
    sw_conditioner_if.slave sw
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a one-cycle threshold the first disagreeing sample already flips.
    localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [HS_BIT:0]   sync;
    hs_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rise_q;
    logic              fall_q;
    logic [DATA_W-1:0] data_q;
    logic              hs_in;
    logic              hs_clean;

    sync2 #(
        .WIDTH(HS_BIT + 1)
    ) u_sync (
        .Clock (Clock),
        .nReset(nReset),
        .d     (sw.SW_raw),
        .q     (sync)
    );

    assign hs_in    = sync[HS_BIT];
    assign hs_clean = (state_q == HIGH_STABLE) || (state_q == HIGH_PEND);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                LOW_STABLE: begin
                    if (hs_in) begin
                        if (SINGLE) begin
                            state_q <= HIGH_STABLE;
                            rise_q  <= 1'b1;
                        end else begin
                            state_q <= LOW_PEND;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                LOW_PEND: begin
                    if (!hs_in) begin
                        // Glitch rejected: partial count discarded.
                        state_q <= LOW_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HIGH_STABLE;
                        cnt_q   <= '0;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH_STABLE: begin
                    if (!hs_in) begin
                        if (SINGLE) begin
                            state_q <= LOW_STABLE;
                            fall_q  <= 1'b1;
                        end else begin
                            state_q <= HIGH_PEND;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                HIGH_PEND: begin
                    if (hs_in) begin
                        state_q <= HIGH_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LOW_STABLE;
                        cnt_q   <= '0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= LOW_STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Loads whenever the handshake was low before this edge: that covers
    // plain tracking, the capture on the rising transition, and resumes one
    // edge after the falling transition.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            data_q <= '0;
        end else if (!hs_clean) begin
            data_q <= sync[DATA_W-1:0];
        end
    end

    assign sw.SW_clean = {hs_clean, data_q};
    assign sw.hs_rise  = rise_q;
    assign sw.hs_fall  = fall_q;
    assign sw.bouncing = (cnt_q != '0);

endmodule

// File: tb/tb_sw_conditioner.sv
module tb_sw_conditioner;
    import picomips_pkg::*;

    localparam int NDB = 4;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;

    sw_conditioner_if sw4 ();
    sw_conditioner_if sw1 ();

    sw_conditioner #(
        .DEBOUNCE_CYCLES(NDB)
    ) u_dut4 (
        .Clock (Clock),
        .nReset(nReset),
        .sw    (sw4)
    );

    sw_conditioner #(
        .DEBOUNCE_CYCLES(1)
    ) u_dut1 (
        .Clock (Clock),
        .nReset(nReset),
        .sw    (sw1)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model for the DEBOUNCE_CYCLES=4 instance: the handshake flips
    // once the last NDB synchronised samples all disagree with it.
    logic [8:0] m_s1, m_s2, m_clean;
    logic       m_rise, m_fall, m_bounce;
    bit         hist[$];

    typedef struct {
        logic [8:0] raw;
        logic [8:0] clean;
        logic       rise;
        logic       fall;
        logic       bounce;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0;
        m_rise = 1'b0; m_fall = 1'b0; m_bounce = 1'b0;
        hist.delete();
    endtask

    task automatic model_step();
        logic [8:0] s;
        logic       deb_old;
        bit         flip;
        s       = m_s2;
        deb_old = m_clean[8];
        hist.push_back(s[8]);
        if (hist.size() > 64) void'(hist.pop_front());
        flip = 1'b0;
        if (hist.size() >= NDB) begin
            flip = 1'b1;
            for (int k = 0; k < NDB; k++)
                if (hist[hist.size() - 1 - k] == deb_old) flip = 1'b0;
        end
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (flip) begin
            m_clean[8] = ~deb_old;
            if (deb_old) m_fall = 1'b1;
            else m_rise = 1'b1;
            hist.delete();
        end
        if (!deb_old) m_clean[7:0] = s[7:0];
        m_bounce = (hist.size() > 0) && (hist[hist.size() - 1] != m_clean[8]);
        m_s2 = m_s1;
        m_s1 = sw4.SW_raw;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    function automatic logic [11:0] obs4();
        return {sw4.SW_clean, sw4.hs_rise, sw4.hs_fall, sw4.bouncing};
    endfunction

    function automatic logic [11:0] obs1();
        return {sw1.SW_clean, sw1.hs_rise, sw1.hs_fall, sw1.bouncing};
    endfunction

    task automatic add_vec(input logic [8:0] raw, input logic [8:0] clean,
                           input logic rise, input logic fall, input logic bounce);
        vec_t v;
        v.raw = raw; v.clean = clean; v.rise = rise; v.fall = fall; v.bounce = bounce;
        vecs.push_back(v);
    endtask

    initial begin
        int rise_cnt;
        int rise_edge;
        int hold;
        bit pat[9];
        logic [8:0] r;

        sw4.SW_raw = '0;
        sw1.SW_raw = '0;
        model_reset();

        // Clean press then release of 9'h1A5.
        for (int i = 0; i < 2; i++) add_vec(9'h1A5, 9'h000, 0, 0, 0);
        for (int i = 0; i < 3; i++) add_vec(9'h1A5, 9'h0A5, 0, 0, 1);
        add_vec(9'h1A5, 9'h1A5, 1, 0, 0);
        for (int i = 0; i < 2; i++) add_vec(9'h1A5, 9'h1A5, 0, 0, 0);
        for (int i = 0; i < 2; i++) add_vec(9'h000, 9'h1A5, 0, 0, 0);
        for (int i = 0; i < 3; i++) add_vec(9'h000, 9'h1A5, 0, 0, 1);
        add_vec(9'h000, 9'h0A5, 0, 1, 0);
        for (int i = 0; i < 2; i++) add_vec(9'h000, 9'h000, 0, 0, 0);
        // Glitch: handshake high for three cycles only.
        for (int i = 0; i < 2; i++) add_vec(9'h100, 9'h000, 0, 0, 0);
        add_vec(9'h100, 9'h000, 0, 0, 1);
        for (int i = 0; i < 2; i++) add_vec(9'h000, 9'h000, 0, 0, 1);
        for (int i = 0; i < 3; i++) add_vec(9'h000, 9'h000, 0, 0, 0);

        // Reset state.
        repeat (2) @(negedge Clock);
        check("reset_dut4", 32'(obs4()), 32'h0);
        check("reset_dut1", 32'(obs1()), 32'h0);
        nReset = 1'b1;
        repeat (4) tick();
        check("idle", 32'(obs4()), 32'h0);

        foreach (vecs[i]) begin
            sw4.SW_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d", i), 32'(obs4()),
                  32'({vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].bounce}));
        end

        // Reset mid-pending with the handshake held high.
        sw4.SW_raw = 9'h1FF;
        repeat (4) tick();
        check("pend_before_reset", 32'(sw4.bouncing), 32'h1);
        #2 nReset = 1'b0;
        model_reset();
        #1 check("async_reset", 32'(obs4()), 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rst_hs_e%0d", e), 32'(sw4.SW_clean[8]), 32'(e >= 6));
            check($sformatf("rst_rise_e%0d", e), 32'(sw4.hs_rise), 32'(e == 6));
        end
        sw4.SW_raw = 9'h000;
        repeat (8) tick();

        // Bouncing press: exactly one rise, at edge 11.
        pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        rise_cnt  = 0;
        rise_edge = 0;
        for (int i = 0; i < 16; i++) begin
            sw4.SW_raw = {(i < 9) ? pat[i] : 1'b1, 8'h00};
            tick();
            if (sw4.hs_rise) begin
                rise_cnt++;
                rise_edge = i + 1;
            end
        end
        check("bounce_rise_count", 32'(rise_cnt), 32'd1);
        check("bounce_rise_edge", 32'(rise_edge), 32'd11);
        check("bounce_final", 32'(sw4.SW_clean), 32'h100);
        sw4.SW_raw = 9'h000;
        repeat (10) tick();

        // Freeze of the data operand while the handshake is high.
        sw4.SW_raw = 9'h13C;
        repeat (7) tick();
        check("freeze_capture", 32'(sw4.SW_clean), 32'h13C);
        sw4.SW_raw = 9'h1FF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("freeze_hold_e%0d", e), 32'(sw4.SW_clean), 32'h13C);
        end
        sw4.SW_raw = 9'h0FF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("freeze_pend_e%0d", e), 32'(sw4.SW_clean), 32'h13C);
        end
        tick();
        check("freeze_fall_clean", 32'(sw4.SW_clean), 32'h03C);
        check("freeze_fall_pulse", 32'(sw4.hs_fall), 32'h1);
        tick();
        check("freeze_resume", 32'(sw4.SW_clean), 32'h0FF);
        sw4.SW_raw = 9'h000;
        repeat (8) tick();

        // DEBOUNCE_CYCLES=1: flip at edge 3, counter never leaves zero.
        sw1.SW_raw = 9'h100;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("n1_rise_e%0d", e), 32'(obs1()),
                  (e < 3) ? 32'h0 : ((e == 3) ? 32'h804 : 32'h800));
        end
        sw1.SW_raw = 9'h000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("n1_fall_e%0d", e), 32'(obs1()),
                  (e < 3) ? 32'h800 : ((e == 3) ? 32'h002 : 32'h0));
        end

        // Randomised run against the model.
        @(negedge Clock);
        nReset = 1'b0;
        model_reset();
        @(negedge Clock);
        nReset = 1'b1;
        hold = 0;
        r    = '0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                r[8] = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            if ($urandom_range(0, 3) == 0) r[7:0] = 8'($urandom);
            sw4.SW_raw = r;
            tick();
            check("rand", 32'(obs4()), 32'({m_clean, m_rise, m_fall, m_bounce}));
            check("rand_excl", 32'(sw4.hs_rise & sw4.hs_fall), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
